// File: rtl/hack_defs.sv
// Shared Hack-platform constants: word width, PC reset value and the
// PC next-state select encoding.
package hack_defs;

    localparam int HACK_WORD_WIDTH     = 16;
    localparam int HACK_PC_RESET_VALUE = 0;

    // Listed in priority order: reset beats load, load beats inc.
    localparam logic [1:0] PC_SEL_RESET = 2'd0;
    localparam logic [1:0] PC_SEL_LOAD  = 2'd1;
    localparam logic [1:0] PC_SEL_INC   = 2'd2;
    localparam logic [1:0] PC_SEL_HOLD  = 2'd3;

endpackage

// File: rtl/or_gate.sv
// Week1 gate library: two-input OR.
module or_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a | b;

endmodule

// File: rtl/register_w.sv
// WIDTH-bit register with synchronous load enable; shared by the PC and
// the Hack A/D registers.
module register_w #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (en)
            q <= d;
    end

endmodule

// File: rtl/program_counter.sv
// Hack program counter: synchronous reset > load > increment > hold.
// Define PC_WRAP_FLAG_EN to add a registered 'wrap' output flagging an
// increment out of all-ones.
module program_counter
    import hack_defs::*;
#(
    parameter int               WIDTH       = HACK_WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(HACK_PC_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
`ifdef PC_WRAP_FLAG_EN
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] out
);

    logic             rl;
    logic             en;
    logic [1:0]       sel;
    logic [WIDTH-1:0] nxt;

    or_gate u_or_rl  (.a(reset), .b(load), .y(rl));
    or_gate u_or_en  (.a(rl),    .b(inc),  .y(en));

    // Reset is tested first so X on load/inc cannot leak while it is held.
    always_comb begin
        sel = PC_SEL_HOLD;
        if (reset)
            sel = PC_SEL_RESET;
        else if (load)
            sel = PC_SEL_LOAD;
        else if (inc)
            sel = PC_SEL_INC;
    end

    always_comb begin
        nxt = out;
        case (sel)
            PC_SEL_RESET: nxt = RESET_VALUE;
            PC_SEL_LOAD:  nxt = in;
            PC_SEL_INC:   nxt = out + WIDTH'(1);
            default:      nxt = out;
        endcase
    end

    register_w #(.WIDTH(WIDTH)) u_pc_reg (
        .clk (clk),
        .en  (en),
        .d   (nxt),
        .q   (out)
    );

`ifdef PC_WRAP_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset)
            wrap <= 1'b0;
        else
            wrap <= (sel == PC_SEL_INC) && (&out);
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed plan plus random
// control traffic against a behavioural PC model.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset, load, inc;
    logic [15:0] in_w, out_w;
`ifdef PC_WRAP_FLAG_EN
    logic        wrap_w;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int pc    = 0;
    int exp_wrap = 0;

    always #5 clk = ~clk;

    program_counter #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_w),
        .load  (load),
        .inc   (inc),
`ifdef PC_WRAP_FLAG_EN
        .wrap  (wrap_w),
`endif
        .out   (out_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle from a negedge, advance the model, check at the next negedge.
    task automatic step(input string tag, input bit r, input bit l, input bit i,
                        input logic [15:0] d);
        reset = r; load = l; inc = i; in_w = d;
        exp_wrap = (!r && !l && i && pc == 65535) ? 1 : 0;
        if (r)      pc = 0;
        else if (l) pc = int'(d);
        else if (i) pc = (pc + 1) % 65536;
        @(posedge clk);
        @(negedge clk);
        chk(tag, {48'd0, out_w}, 64'(pc));
`ifdef PC_WRAP_FLAG_EN
        chk({tag, "_wrap"}, {63'd0, wrap_w}, 64'(exp_wrap));
`endif
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; inc = 1'b0; in_w = '0;
        @(negedge clk);

        // Reset beats load and inc
        step("reset", 1, 1, 1, 16'h1234);
        chk("reset_val", {48'd0, out_w}, 64'h0);

        // Count then hold
        for (int k = 0; k < 5; k++) step("count", 0, 0, 1, 16'hBEEF);
        chk("count5", {48'd0, out_w}, 64'd5);
        for (int k = 0; k < 3; k++) step("idle", 0, 0, 0, 16'h5555);
        chk("idle5", {48'd0, out_w}, 64'd5);

        // Load beats inc; in taken unincremented
        step("ld_pri", 0, 1, 1, 16'h00A0);
        chk("ld_pri_val", {48'd0, out_w}, 64'h00A0);
        step("ld_inc", 0, 0, 1, 16'h0000);
        chk("ld_inc_val", {48'd0, out_w}, 64'h00A1);

        // Wrap-around
        step("ld_fffe", 0, 1, 0, 16'hFFFE);
        step("to_ffff", 0, 0, 1, 16'h0000);
        step("to_0000", 0, 0, 1, 16'h0000);
        chk("wrap_val", {48'd0, out_w}, 64'h0);
        step("post_wrap", 0, 0, 0, 16'h0000);

        // Reset mid-count
        step("ld_0f", 0, 1, 0, 16'h000F);
        step("to_10", 0, 0, 1, 16'h0000);
        step("mid_rst", 1, 0, 1, 16'h0000);
        step("resume", 0, 0, 1, 16'h0000);
        chk("resume_val", {48'd0, out_w}, 64'h1);

        // Hold with in toggling
        step("ld_7fff", 0, 1, 0, 16'h7FFF);
        for (int k = 0; k < 10; k++) step("hold", 0, 0, 0, 16'(k[0] ? 16'hAAAA : 16'h5555));
        chk("hold_val", {48'd0, out_w}, 64'h7FFF);

        // X on controls while reset is held
        step("ld_x_pre", 0, 1, 0, 16'h4321);
        reset = 1'b1; load = 1'bx; inc = 1'bx; in_w = 16'h9999;
        pc = 0;
        @(posedge clk);
        @(negedge clk);
        chk("x_rst", {48'd0, out_w}, 64'h0);
`ifdef PC_WRAP_FLAG_EN
        chk("x_rst_wrap", {63'd0, wrap_w}, 64'h0);
`endif

        // Random traffic, biased toward loads near all-ones to exercise wrap
        for (int k = 0; k < 400; k++) begin
            bit r, l, i;
            logic [15:0] d;
            r = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 7) == 0);
            i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                d = 16'hFFFF - 16'($urandom_range(0, 3));
            else
                d = 16'($urandom);
            step("rand", r, l, i, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
